// File: rtl/cpu_pkg.sv
// Shared processor definitions: opcodes, instruction field positions, fetch defaults
// and the {pc, instr} record that flows from fetch to decode.
package cpu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_LOAD = 6'b000010;

  localparam int OPC_MSB = 31, OPC_LSB = 26;
  localparam int RD_MSB  = 25, RD_LSB  = 21;
  localparam int RS_MSB  = 20, RS_LSB  = 16;
  localparam int RT_MSB  = 15, RT_LSB  = 11;
  localparam int IMM_MSB = 15, IMM_LSB = 0;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries; flush empties it in one edge and wins over push/pop.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [AW:0]  count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues reads to a 1-cycle imem and buffers the returned
// words so decode stalls never lose an instruction. Redirect flushes everything.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction_out,
  output logic        instr_valid,
  output logic [31:0] pc_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  logic [31:0]  pc_q, pc_d, req_pc_q, req_pc_d;
  logic         inflight_q, inflight_d;
  logic [AW:0]  q_count;
  logic [AW+1:0] occ;
  logic         q_push, q_pop;
  fetch_entry_t q_head, q_wdata;

  // The in-flight word already owns a slot, so occupancy counts it.
  assign occ       = {1'b0, q_count} + (AW+2)'(inflight_q);
  assign imem_req  = reset && !redirect_valid && (occ < DEPTH_W);
  assign imem_addr = pc_q;

  assign instr_valid     = (q_count != '0);
  assign instruction_out = instr_valid ? q_head.instr : NOP_INSTR;
  assign pc_out          = instr_valid ? q_head.pc : 32'h0;

  assign q_push  = inflight_q && !redirect_valid;
  assign q_pop   = instr_valid && !stall && !redirect_valid;
  assign q_wdata = '{pc: req_pc_q, instr: imem_rdata};

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (imem_req) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_wdata),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .count     (q_count),
    .head      (q_head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a scoreboard queue holds every issued fetch
// (queued or in flight) and is popped as decode accepts instructions.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] WPC   = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, rv = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic        req, vld, w_req, w_vld;
  logic [31:0] addr, rdata, iout, pco;
  logic [31:0] w_addr, w_rdata, w_iout, w_pco;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .imem_req(req), .imem_addr(addr), .imem_rdata(rdata),
    .stall(stall), .redirect_valid(rv), .redirect_pc(rpc),
    .instruction_out(iout), .instr_valid(vld), .pc_out(pco)
  );

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(WPC), .NOP_INSTR(NOP)) dut_w (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instruction_out(w_iout), .instr_valid(w_vld), .pc_out(w_pco)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0022_1800;
      32'h4:   return 32'h0481_2800;
      32'h8:   return 32'h08C7_0064;
      default: return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endcase
  endfunction

  // 1-cycle-latency instruction memory
  always @(posedge clk) begin
    rdata   <= mem(addr);
    w_rdata <= mem(w_addr);
  end

  logic [63:0] sb[$];
  logic [31:0] exp_pc;
  bit          inflight_m;
  bit          wrap_on = 1'b0;
  int          wcyc;
  int          errs = 0, nchk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_pc     = RPC;
    inflight_m = 1'b0;
    wcyc       = 0;
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cyc(input bit s, input bit r, input logic [31:0] p);
    bit ev, er;
    logic [31:0] wexp;
    stall = s; rv = r; rpc = p;
    #1;
    ev = (sb.size() > (inflight_m ? 1 : 0));
    er = !r && (sb.size() < DEPTH);
    chk("imem_req", {31'b0, req}, {31'b0, er});
    chk("imem_addr", addr, exp_pc);
    chk("instr_valid", {31'b0, vld}, {31'b0, ev});
    if (ev) begin
      chk("pc_out", pco, sb[0][63:32]);
      chk("instruction_out", iout, sb[0][31:0]);
    end else begin
      chk("pc_out_idle", pco, 32'h0);
      chk("instr_idle", iout, NOP);
    end
    if (wrap_on) begin
      if (wcyc < 3) begin
        wexp = WPC + 32'(4 * wcyc);
        chk("wrap_addr", w_addr, wexp);
      end
      if (wcyc >= 2 && wcyc < 5) begin
        wexp = WPC + 32'(4 * (wcyc - 2));
        chk("wrap_valid", {31'b0, w_vld}, 32'h1);
        chk("wrap_pc_out", w_pco, wexp);
        chk("wrap_instr", w_iout, mem(wexp));
      end
      wcyc++;
    end
    if (r) begin
      sb.delete();
      inflight_m = 1'b0;
      exp_pc = {p[31:2], 2'b00};
    end else begin
      if (ev && !s) void'(sb.pop_front());
      if (er) begin
        sb.push_back({exp_pc, mem(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
      inflight_m = er;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_valid", {31'b0, vld}, 32'h0);
    chk("rst_instr", iout, NOP);
    chk("rst_pc_out", pco, 32'h0);
    chk("rst_addr", addr, RPC);
    chk("rst_wrap_addr", w_addr, WPC);
    @(negedge clk);
    reset = 1'b1;
    wrap_on = 1'b1;

    // startup: addr 0,4 then valid after the second edge
    repeat (2) cyc(0, 0, 32'h0);
    // decode stalls long enough to fill the queue, then drains
    repeat (8) cyc(1, 0, 32'h0);
    repeat (10) cyc(0, 0, 32'h0);

    // build up 3 queued + 1 in flight, then redirect
    for (int i = 0; i < 10 && !(sb.size() == 4 && inflight_m); i++) cyc(1, 0, 32'h0);
    chk("pre_redirect_valid", {31'b0, vld}, 32'h1);
    cyc(1, 1, 32'h40);
    repeat (6) cyc(0, 0, 32'h0);

    // misaligned redirect target
    cyc(0, 1, 32'h43);
    repeat (4) cyc(0, 0, 32'h0);

    // reset between clock edges while streaming
    #3 reset = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, vld}, 32'h0);
    chk("midrst_req", {31'b0, req}, 32'h0);
    chk("midrst_pc_out", pco, 32'h0);
    chk("midrst_instr", iout, NOP);
    chk("midrst_addr", addr, RPC);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) cyc(0, 0, 32'h0);

    // mixed stalls
    for (int i = 0; i < 24; i++) cyc(1'($urandom_range(0, 1)), 0, 32'h0);
    cyc(0, 1, 32'h100);
    for (int i = 0; i < 12; i++) cyc(1'($urandom_range(0, 1)), 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream fetch stage of the 4-stage pipelined processor; produces the instruction_in stream consumed by decode.
- Owns the PC and issues word reads to a 1-cycle-latency instruction memory.
- Buffers fetched words in a small prefetch queue so decode stalls never drop instructions.
- Accepts a redirect (new PC) that flushes all buffered and in-flight fetches.

Parameters:
- DEPTH, 4, prefetch queue entries (power of two, >=2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0000, value driven on instruction_out when no valid instruction

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- imem_req  output  1  read request this cycle
- imem_addr  output  32  word-aligned read address (current PC)
- imem_rdata  input  32  read data, valid exactly one cycle after the imem_req cycle
- stall  input  1  decode cannot accept an instruction this cycle
- redirect_valid  input  1  load new PC and flush
- redirect_pc  input  32  redirect target
- instruction_out  output  32  instruction to decode (the processor's instruction_in)
- instr_valid  output  1  instruction_out/pc_out valid
- pc_out  output  32  address of instruction_out

Behaviour:
- Reset (async, reset=0): pc<=RESET_PC, queue empty, in-flight flag cleared.
  - instr_valid=0, instruction_out=NOP_INSTR, pc_out=0, imem_req=0, imem_addr=RESET_PC.
  - imem_req is forced 0 while reset=0.
- Issue: imem_req = !redirect_valid && (count + inflight < DEPTH); imem_addr = pc.
  - On an edge with imem_req=1: pc<=pc+4, with modulo 2^32 wrap (FFFFFFFC -> 0).
  - The same edge sets inflight=1 and latches req_pc=pc.
  - On an edge with imem_req=0: inflight<=0.
- Capture: on an edge where inflight=1 and redirect_valid=0, push {req_pc, imem_rdata} into the queue.
- Output: when the queue is non-empty, instr_valid=1 and instruction_out/pc_out show the queue head (combinational from storage).
  - When the queue is empty: instr_valid=0, instruction_out=NOP_INSTR, pc_out=0.
- Pop: on an edge with instr_valid=1 and stall=0.
  - Push and pop on the same edge are both performed; count is unchanged.
- Latency: first imem_req is in the cycle after reset release. instr_valid rises after the second edge. Steady-state throughput is one instruction per cycle with stall=0.
- Full: the issue rule reserves a slot for the in-flight word, so overflow is impossible. When count+inflight=DEPTH, imem_req=0.
- Redirect (on an edge with redirect_valid=1):
  - Queue cleared, inflight cleared (the in-flight response is discarded), pc<={redirect_pc[31:2],2'b00}.
  - Redirect takes priority over simultaneous push, pop and issue.
  - First post-redirect instruction becomes valid two edges later.
- Misaligned redirect_pc: low two bits are ignored.
- Reset asserted mid-operation: immediate return to the reset state, and outputs change without waiting for clk. Fetch restarts at RESET_PC after release.

Decomposition:
- Shared package cpu_pkg:
  - OP_ADD=6'b000000, OP_SUB=6'b000001, OP_LOAD=6'b000010
  - instruction field positions: opcode[31:26], rd[25:21], rs[20:16], rt[15:11], imm[15:0]
  - NOP_INSTR, RESET_PC defaults
- Sub-module fetch_queue: synchronous FIFO of 64-bit {pc, instr} entries.
  - Depth DEPTH; push, pop, flush, count, head outputs; async active-low reset.

Test Plan:
- Reset release, imem preloaded with word0=32'h00221800 (ADD R1,R2,R3), word1=32'h04812800 (SUB R4,R1,R5), word2=32'h08C70064 (LOAD R6,100(R7)) -> imem_addr 0,4,8 on consecutive cycles; instr_valid high after second edge; outputs in order with pc_out 0,4,8.
- stall=1 held 8 cycles after first valid -> queue reaches 4 entries, imem_req drops to 0, head held stable; on release, addresses 0,4,8,12 delivered consecutively, then fetch resumes at 16 with no gap or duplicate.
- redirect_valid=1, redirect_pc=32'h40 while 3 entries are queued and a request is in flight -> next edge instr_valid=0; imem_addr=40 issued; instr_valid returns two edges after the redirect with pc_out=40; no pre-redirect word ever appears.
- redirect_pc=32'h43 -> imem_addr=32'h40, pc_out=32'h40.
- RESET_PC=32'hFFFFFFF8 -> imem_addr FFFFFFF8, FFFFFFFC, 00000000; pc_out follows.
- reset driven low between clock edges while streaming -> instr_valid=0 and imem_req=0 immediately; after release, first imem_addr=RESET_PC and no stale queue contents.
